// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - mode encodings shared by the universal shift register and its cells
package univ_shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one register bit: 4:1 next-value mux into a sync-reset, enabled flip-flop
module sr_cell
   import univ_shift_pkg::*;
#(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  en,
   input  mode_t sel,
   input  logic  right_in,
   input  logic  left_in,
   input  logic  d_in,
   output logic  q
);

   logic w_next;
   logic r_q;

   always_comb begin
      w_next = r_q;
      case (sel)
         MODE_HOLD: w_next = r_q;
         MODE_SHR:  w_next = right_in;
         MODE_SHL:  w_next = left_in;
         MODE_LOAD: w_next = d_in;
         default:   w_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= RESET_BIT;
      end else if (en) begin
         r_q <= w_next;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with saturating shift counter; optional qbar via UNIV_SHIFT_REG_QBAR_EN
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             drained
`ifdef UNIV_SHIFT_REG_QBAR_EN
   ,
   output logic [WIDTH-1:0] qbar
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   mode_t            w_mode;
   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_right;
   logic [WIDTH-1:0] w_left;
   logic             w_shift;
   logic [CNT_W-1:0] r_shift_cnt;

   assign w_mode = mode_t'(mode);

   // Bit i takes q[i+1] on shift right and q[i-1] on shift left; the ends take the serial inputs.
   assign w_right = {sin_r, w_q[WIDTH-1:1]};
   assign w_left  = {w_q[WIDTH-2:0], sin_l};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(
         .RESET_BIT (RESET_VAL[i])
      ) u_cell (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .sel      (w_mode),
         .right_in (w_right[i]),
         .left_in  (w_left[i]),
         .d_in     (d[i]),
         .q        (w_q[i])
      );
   end

   assign w_shift = (w_mode == MODE_SHR) || (w_mode == MODE_SHL);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift_cnt <= '0;
      end else if (en) begin
         if (w_mode == MODE_LOAD) begin
            r_shift_cnt <= '0;
         end else if (w_shift && (r_shift_cnt != CNT_MAX)) begin
            r_shift_cnt <= r_shift_cnt + 1'b1;
         end
      end
   end

   assign q         = w_q;
   assign sout_r    = w_q[0];
   assign sout_l    = w_q[WIDTH-1];
   assign shift_cnt = r_shift_cnt;
   assign drained   = (r_shift_cnt == CNT_MAX);

`ifdef UNIV_SHIFT_REG_QBAR_EN
   assign qbar = ~w_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - randomized and directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] d = 8'h00;
   logic       sin_r = 1'b0;
   logic       sin_l = 1'b0;

   logic [7:0] q0, q1;
   logic       sout_r0, sout_l0, sout_r1, sout_l1;
   logic [3:0] cnt0, cnt1;
   logic       drained0, drained1;
`ifdef UNIV_SHIFT_REG_QBAR_EN
   logic [7:0] qbar0, qbar1;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: register contents and shift count for each reset value.
   logic [7:0] m_q0, m_q1;
   int         m_cnt;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .q(q0), .sout_r(sout_r0), .sout_l(sout_l0),
      .shift_cnt(cnt0), .drained(drained0)
`ifdef UNIV_SHIFT_REG_QBAR_EN
      , .qbar(qbar0)
`endif
   );

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hF0)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .q(q1), .sout_r(sout_r1), .sout_l(sout_l1),
      .shift_cnt(cnt1), .drained(drained1)
`ifdef UNIV_SHIFT_REG_QBAR_EN
      , .qbar(qbar1)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] rv);
      logic [7:0] r;
      r = cur;
      if (reset)                       r = rv;
      else if (en && mode == 2'b01)    r = (cur >> 1) | (8'(sin_r) << 7);
      else if (en && mode == 2'b10)    r = (cur << 1) | 8'(sin_l);
      else if (en && mode == 2'b11)    r = d;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      m_q0 = model_next(m_q0, 8'h00);
      m_q1 = model_next(m_q1, 8'hF0);
      if (reset || (en && mode == 2'b11)) m_cnt = 0;
      else if (en && (mode == 2'b01 || mode == 2'b10) && m_cnt < 8) m_cnt++;
      #1;
      check("q0", q0, m_q0);
      check("q1", q1, m_q1);
      check("cnt0", cnt0, m_cnt);
      check("cnt1", cnt1, m_cnt);
      check("drained0", drained0, m_cnt == 8);
      check("sout_r0", sout_r0, m_q0 % 2);
      check("sout_l0", sout_l0, m_q0 / 128);
      check("sout_r1", sout_r1, m_q1 % 2);
      check("sout_l1", sout_l1, m_q1 / 128);
`ifdef UNIV_SHIFT_REG_QBAR_EN
      check("qbar0", qbar0, 8'hFF ^ m_q0);
      check("qbar1", qbar1, 8'hFF ^ m_q1);
`endif
   endtask

   task automatic load(input logic [7:0] v);
      reset = 1'b0; en = 1'b1; mode = 2'b11; d = v;
      step();
   endtask

   initial begin
      logic [7:0] seq;
      m_q0 = 'x; m_q1 = 'x; m_cnt = 0;

      // Reset wins over a simultaneous load of all ones.
      reset = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF;
      step();
      check("rst_q", q0, 8'h00);
      check("rst_cnt", cnt0, 4'd0);
      check("rst_drained", drained0, 1'b0);
      check("rst_q_f0", q1, 8'hF0);
      check("rst_sout_l_f0", sout_l1, 1'b1);

      // Load A5 and drain it out to the right.
      load(8'hA5);
      seq = 8'b1010_0101;
      reset = 1'b0; en = 1'b1; mode = 2'b01; sin_r = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_sout_r%0d", i), sout_r0, seq[i]);
         step();
      end
      check("drain_q", q0, 8'h00);
      check("drain_cnt", cnt0, 4'd8);
      check("drain_flag", drained0, 1'b1);

      // Shift left with serial one in, then saturate the counter.
      load(8'h81);
      mode = 2'b10; sin_l = 1'b1;
      step();
      check("shl_q", q0, 8'h03);
      check("shl_cnt", cnt0, 4'd1);
      for (int i = 0; i < 8; i++) step();
      check("shl_sat_cnt", cnt0, 4'd8);
      check("shl_sat_q", q0, 8'hFF);

      // Enable low blocks shifts; mode hold changes nothing.
      load(8'h3C);
      en = 1'b0; mode = 2'b01;
      for (int i = 0; i < 3; i++) step();
      check("hold_en_q", q0, 8'h3C);
      check("hold_en_cnt", cnt0, 4'd0);
      en = 1'b1; mode = 2'b00;
      step();
      check("hold_mode_q", q0, 8'h3C);

      // Reset in the same cycle as a load, after four shifts.
      load(8'h0F);
      mode = 2'b10; sin_l = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("mid_cnt", cnt0, 4'd4);
      reset = 1'b1; mode = 2'b11; d = 8'h55;
      step();
      check("mid_rst_q", q0, 8'h00);
      check("mid_rst_cnt", cnt0, 4'd0);
      check("mid_rst_q_f0", q1, 8'hF0);

      // Direction flip without an idle cycle counts into the same counter.
      load(8'h18);
      mode = 2'b01; sin_r = 1'b1; step();
      mode = 2'b10; sin_l = 1'b1; step();
      check("flip_q", q0, 8'h19);
      check("flip_cnt", cnt0, 4'd2);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 19) == 0);
         en    = ($urandom_range(0, 4) != 0);
         mode  = 2'($urandom_range(0, 3));
         d     = 8'($urandom);
         sin_r = 1'($urandom);
         sin_l = 1'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  operation enable; 0 holds all state.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin_r  input  1  serial input shifted into q[WIDTH-1] on shift right.
REQ-009 sin_l  input  1  serial input shifted into q[0] on shift left.
REQ-010 q  output  WIDTH  register contents.
REQ-011 sout_r  output  1  serial output for shift right, equal to q[0].
REQ-012 sout_l  output  1  serial output for shift left, equal to q[WIDTH-1].
REQ-013 shift_cnt  output  clog2(WIDTH+1)  count of shifts since the last load or reset.
REQ-014 drained  output  1  high when shift_cnt equals WIDTH.

Function
REQ-015 Every q update SHALL occur only at the rising edge of clk, with one-cycle latency from the inputs to q.
REQ-016 When en=0 or mode=00, q and shift_cnt SHALL hold their values.
REQ-017 When en=1 and mode=01, q SHALL become {sin_r, q[WIDTH-1:1]}.
REQ-018 When en=1 and mode=10, q SHALL become {q[WIDTH-2:0], sin_l}.
REQ-019 When en=1 and mode=11, q SHALL become d and shift_cnt SHALL become 0.
REQ-020 Each enabled shift (mode 01 or 10) SHALL increment shift_cnt by 1 while shift_cnt<WIDTH.
REQ-021 Once shift_cnt reaches WIDTH, it SHALL saturate there, and further shifts SHALL still move q.
REQ-022 drained, sout_r and sout_l SHALL be combinational decodes of registered state, with no extra cycle of delay.
REQ-023 Direction changes between consecutive cycles SHALL need no idle cycle, and both directions SHALL count into the same shift_cnt.

Reset
REQ-024 On a rising clk edge with reset=1, q SHALL become RESET_VAL and shift_cnt SHALL become 0, regardless of en, mode or d.
REQ-025 reset SHALL take precedence over every operation, including a load or shift in the same cycle.
REQ-026 reset SHALL have no effect between clock edges; q SHALL change only at a rising clk edge.
REQ-027 After reset, drained=0, sout_r=RESET_VAL[0] and sout_l=RESET_VAL[WIDTH-1].

Configuration
REQ-028 Macro UNIV_SHIFT_REG_QBAR_EN defined: an extra output qbar (WIDTH bits) SHALL be present and equal to ~q at all times, including during and after reset.
REQ-029 Macro UNIV_SHIFT_REG_QBAR_EN undefined: the qbar port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 A shared package univ_shift_pkg SHALL hold the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, plus the 2-bit mode typedef.
REQ-031 Each bit SHALL be an instance of sub-module sr_cell: a 4:1 next-value mux (hold, right neighbour, left neighbour, d) feeding a D flip-flop with synchronous reset and enable.
REQ-032 The shift counter and drained decode SHALL live in the top level, not in sr_cell.

Verification (WIDTH=8, RESET_VAL=8'h00 unless noted)
REQ-033 Reset: reset=1 for one edge with en=1, mode=11, d=8'hFF -> q=8'h00, shift_cnt=0, drained=0.
REQ-034 Load then shift right: load 8'hA5, then 8 edges of mode=01 with sin_r=0 -> sout_r sequence 1,0,1,0,0,1,0,1; final q=8'h00, shift_cnt=8, drained=1.
REQ-035 Shift left with wrap-in: load 8'h81, then 1 edge of mode=10 with sin_l=1 -> q=8'h03, shift_cnt=1; a 9th consecutive shift leaves shift_cnt=8.
REQ-036 Hold and enable: load 8'h3C, then en=0 with mode=01 for 3 edges -> q=8'h3C, shift_cnt=0; then mode=00 with en=1 -> unchanged.
REQ-037 Reset mid-operation: after 4 shifts, assert reset in the same cycle as a load of 8'h55 -> q=8'h00 and shift_cnt=0; with RESET_VAL=8'hF0, q=8'hF0.
REQ-038 Macro build: with UNIV_SHIFT_REG_QBAR_EN defined, run REQ-034 -> qbar equals ~q on every cycle; without the macro, the bench compiles with no qbar reference.
